pc_redirect_unit: RTL and testbench

- Downstream consumer of the branch-controller taken signal (`w`) in the RV32 pipelined core.
- Owns the fetch PC register and selects the next PC from sequential, branch, JAL or JALR sources.
- Generates IF/ID and ID/EX flush pulses and squashes redirects from wrong-path instructions.
- Holds a pending redirect across pipeline freezes so no taken branch is lost.

---
 rtl/pipeline_pkg.sv | 27 ++
 rtl/redirect_squash_fsm.sv | 105 ++++++++++
 rtl/pc_redirect_unit.sv | 140 ++++++++++++++
 tb/tb_pc_redirect_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the RV32 pipeline front end: datapath width, the
// PC value loaded on reset, the redirect FSM state encoding and the encoding
// of the next-PC source selected by the redirect unit.
// ---------------------------------------------------------------------------
package pipeline_pkg;

   localparam int          XLEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   // States of the redirect/squash controller
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      PENDING = 2'd1,
      SQUASH  = 2'd2
   } redirect_state_e;

   // Where the next fetch PC comes from
   typedef enum logic [1:0] {
      SRC_SEQ  = 2'd0,
      SRC_BR   = 2'd1,
      SRC_JAL  = 2'd2,
      SRC_JALR = 2'd3
   } redirect_src_e;

endpackage

// File: rtl/redirect_squash_fsm.sv
// ---------------------------------------------------------------------------
// redirect_squash_fsm
// Owns the redirect state (RUN / PENDING / SQUASH), the wrong-path squash
// counter and the captured target of a redirect that arrived during a freeze.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   freeze_i        global pipeline hold
//   req_i           redirect request from EX (already qualified by source)
//   target_i        aligned target of the live request
//   load_target_o   the PC register must load target_sel_o this cycle
//   target_sel_o    target to load (captured one when leaving PENDING)
//   flush_o         flush pulse for IF/ID and ID/EX, same cycle as the load
//   busy_o          registered flag, high whenever the FSM is not in RUN
// ---------------------------------------------------------------------------
module redirect_squash_fsm
   import pipeline_pkg::*;
#(
   parameter int XLEN_P        = XLEN,
   parameter int SQUASH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze_i,
   input  logic              req_i,
   input  logic [XLEN_P-1:0] target_i,
   output logic              load_target_o,
   output logic [XLEN_P-1:0] target_sel_o,
   output logic              flush_o,
   output logic              busy_o
);

   localparam int CNT_W = 3;

   redirect_state_e   state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [XLEN_P-1:0] pendTarget_q;
   logic              busy_q;

   // A redirect is applied either straight from RUN when the pipe is not
   // frozen, or from PENDING on the first unfrozen cycle. Flushes track the
   // load exactly, so they can never fire while freeze is high.
   always_comb begin
      load_target_o = 1'b0;
      target_sel_o  = target_i;
      unique case (state_q)
         RUN:     load_target_o = req_i & ~freeze_i;
         PENDING: begin
            load_target_o = ~freeze_i;
            target_sel_o  = pendTarget_q;
         end
         default: load_target_o = 1'b0;
      endcase
      flush_o = load_target_o;
   end

   // State, squash counter and pending capture. The counter only moves on
   // unfrozen cycles; when it is about to leave 1 the controller returns to
   // RUN, so the wrong-path window is exactly SQUASH_CYCLES unfrozen cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         cnt_q        <= '0;
         pendTarget_q <= '0;
         busy_q       <= 1'b0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (req_i) begin
                  busy_q <= 1'b1;
                  if (freeze_i) begin
                     pendTarget_q <= target_i;
                     state_q      <= PENDING;
                  end else begin
                     cnt_q   <= CNT_W'(SQUASH_CYCLES);
                     state_q <= SQUASH;
                  end
               end
            end
            PENDING: begin
               if (!freeze_i) begin
                  cnt_q   <= CNT_W'(SQUASH_CYCLES);
                  state_q <= SQUASH;
               end
            end
            SQUASH: begin
               if (!freeze_i) begin
                  cnt_q <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     state_q <= RUN;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= RUN;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/pc_redirect_unit.sv
// ---------------------------------------------------------------------------
// pc_redirect_unit
// Owns the fetch PC and picks the next PC from the sequential path or a
// branch / JAL / JALR redirect coming from EX. Produces the IF/ID and ID/EX
// flush pulses and, through redirect_squash_fsm, ignores redirects from the
// wrong-path instructions that follow an applied redirect and holds a
// redirect that arrives during a freeze.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   freeze                 global hold (memory busy)
//   stall                  load-use stall, holds PC when no redirect
//   taken, jal, jalr       redirect requests from EX
//   branch_target          PC+imm for branch / JAL
//   jalr_target            rs1+imm for JALR
//   pc, pc_plus4           current fetch PC and PC+4 (wrapping)
//   flush_if_id/id_ex      flush pulses, high in the cycle a redirect applies
//   redirect_busy          redirect controller not in RUN
//
// Optional build macro PC_REDIRECT_STATS_EN adds input is_branch and the
// saturating 32-bit outputs br_count and redirect_count.
// ---------------------------------------------------------------------------
module pc_redirect_unit
   import pipeline_pkg::*;
#(
   parameter int              XLEN_P        = XLEN,
   parameter logic [XLEN_P-1:0] RESET_PC_P  = XLEN_P'(RESET_PC),
   parameter int              SQUASH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              stall,
   input  logic              taken,
   input  logic              jal,
   input  logic              jalr,
   input  logic [XLEN_P-1:0] branch_target,
   input  logic [XLEN_P-1:0] jalr_target,
`ifdef PC_REDIRECT_STATS_EN
   input  logic              is_branch,
   output logic [31:0]       br_count,
   output logic [31:0]       redirect_count,
`endif
   output logic [XLEN_P-1:0] pc,
   output logic [XLEN_P-1:0] pc_plus4,
   output logic              flush_if_id,
   output logic              flush_id_ex,
   output logic              redirect_busy
);

   redirect_src_e     src;
   logic              req;
   logic [XLEN_P-1:0] reqTarget;
   logic              loadTarget;
   logic [XLEN_P-1:0] targetSel;
   logic              flush;
   logic [XLEN_P-1:0] pc_q;
   logic [XLEN_P-1:0] pc_d;

   // Source priority is jalr > jal > taken. JALR clears bit 0 of its sum and
   // every target is forced word aligned before it reaches the PC.
   always_comb begin
      src       = SRC_SEQ;
      reqTarget = branch_target & ~XLEN_P'(3);
      if (jalr) begin
         src       = SRC_JALR;
         reqTarget = (jalr_target & ~XLEN_P'(1)) & ~XLEN_P'(3);
      end else if (jal) begin
         src = SRC_JAL;
      end else if (taken) begin
         src = SRC_BR;
      end
      req = (src != SRC_SEQ);
   end

   redirect_squash_fsm #(
      .XLEN_P        (XLEN_P),
      .SQUASH_CYCLES (SQUASH_CYCLES)
   ) u_fsm (
      .clk           (clk),
      .rst           (rst),
      .freeze_i      (freeze),
      .req_i         (req),
      .target_i      (reqTarget),
      .load_target_o (loadTarget),
      .target_sel_o  (targetSel),
      .flush_o       (flush),
      .busy_o        (redirect_busy)
   );

   // Next PC: an applied redirect beats everything (including stall);
   // otherwise freeze or stall hold and the default is the sequential path.
   always_comb begin
      pc_d = pc_q;
      if (loadTarget) begin
         pc_d = targetSel;
      end else if (!freeze && !stall) begin
         pc_d = pc_q + XLEN_P'(4);
      end
   end

   // The fetch PC register itself
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC_P;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc          = pc_q;
   assign pc_plus4    = pc_q + XLEN_P'(4);
   assign flush_if_id = flush;
   assign flush_id_ex = flush;

`ifdef PC_REDIRECT_STATS_EN
   logic [31:0] brCount_q;
   logic [31:0] redirectCount_q;

   // Event counters: branches seen while in RUN and unfrozen, and applied
   // redirects. Both stick at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         brCount_q       <= '0;
         redirectCount_q <= '0;
      end else begin
         if (!redirect_busy && is_branch && !freeze && (brCount_q != 32'hFFFF_FFFF)) begin
            brCount_q <= brCount_q + 32'd1;
         end
         if (flush && (redirectCount_q != 32'hFFFF_FFFF)) begin
            redirectCount_q <= redirectCount_q + 32'd1;
         end
      end
   end

   assign br_count       = brCount_q;
   assign redirect_count = redirectCount_q;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_redirect_unit
// Scoreboard bench for pc_redirect_unit. A driver applies directed and random
// input vectors each cycle, advances a behavioural model of the fetch PC and
// pushes the outputs the DUT should show into a queue; a monitor pops and
// compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_pc_redirect_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          SQ     = 2;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pcPlus4;
      logic        flush;
      logic        busy;
   } expect_t;

   logic        clk;
   logic        rst;
   logic        freeze;
   logic        stall;
   logic        taken;
   logic        jal;
   logic        jalr;
   logic [31:0] branch_target;
   logic [31:0] jalr_target;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic        redirect_busy;

   expect_t     expQ[$];
   int          vectors;
   int          miscompares;
   bit          driverDone;

   // Reference model: the fetch PC, whether a redirect is parked behind a
   // freeze, and how many unfrozen cycles of wrong-path requests remain.
   logic [31:0] mPc;
   bit          mPendValid;
   logic [31:0] mPendTarget;
   int          mIgnore;

   pc_redirect_unit dut (
      .clk           (clk),
      .rst           (rst),
      .freeze        (freeze),
      .stall         (stall),
      .taken         (taken),
      .jal           (jal),
      .jalr          (jalr),
      .branch_target (branch_target),
      .jalr_target   (jalr_target),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .flush_if_id   (flush_if_id),
      .flush_id_ex   (flush_id_ex),
      .redirect_busy (redirect_busy)
   );

   // 10 time-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] modelTarget();
      if (jalr) return jalr_target & 32'hFFFF_FFFC;
      return branch_target & 32'hFFFF_FFFC;
   endfunction

   // One clock edge of the model, using the inputs that were live before it
   task automatic modelAdvance();
      bit          req;
      logic [31:0] tgt;
      req = taken | jal | jalr;
      tgt = modelTarget();
      if (rst) begin
         mPc = RST_PC; mPendValid = 0; mIgnore = 0;
      end else if (freeze) begin
         if (!mPendValid && mIgnore == 0 && req) begin
            mPendValid = 1; mPendTarget = tgt;
         end
      end else if (mPendValid) begin
         mPc = mPendTarget; mPendValid = 0; mIgnore = SQ;
      end else if (mIgnore == 0 && req) begin
         mPc = tgt; mIgnore = SQ;
      end else begin
         if (mIgnore > 0) mIgnore--;
         if (!stall) mPc = mPc + 32'd4;
      end
   endtask

   // Drive one cycle worth of inputs, then queue what the DUT should show
   task automatic applyStimulus(input logic r, input logic fz, input logic st,
                                input logic tk, input logic jl, input logic jr,
                                input logic [31:0] bt, input logic [31:0] jt);
      expect_t e;
      @(posedge clk);
      modelAdvance();
      #1;
      rst = r; freeze = fz; stall = st; taken = tk; jal = jl; jalr = jr;
      branch_target = bt; jalr_target = jt;
      #1;
      e.pc      = mPc;
      e.pcPlus4 = mPc + 32'd4;
      e.flush   = !freeze && (mPendValid || (mIgnore == 0 && (taken | jal | jalr)));
      e.busy    = mPendValid || (mIgnore > 0);
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input expect_t e);
      vectors++;
      if (pc !== e.pc) begin
         miscompares++;
         $display("[TB] FAIL pc: got %h expected %h at %0t", pc, e.pc, $time);
      end
      if (pc_plus4 !== e.pcPlus4) begin
         miscompares++;
         $display("[TB] FAIL pc_plus4: got %h expected %h at %0t", pc_plus4, e.pcPlus4, $time);
      end
      if (flush_if_id !== e.flush) begin
         miscompares++;
         $display("[TB] FAIL flush_if_id: got %b expected %b at %0t", flush_if_id, e.flush, $time);
      end
      if (flush_id_ex !== e.flush) begin
         miscompares++;
         $display("[TB] FAIL flush_id_ex: got %b expected %b at %0t", flush_id_ex, e.flush, $time);
      end
      if (redirect_busy !== e.busy) begin
         miscompares++;
         $display("[TB] FAIL redirect_busy: got %b expected %b at %0t", redirect_busy, e.busy, $time);
      end
   endtask

   // Monitor: compare whatever the driver has queued, mid-cycle
   initial begin
      expect_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   // Driver: directed scenarios first, then randomized traffic
   initial begin
      int drain;
      vectors = 0; miscompares = 0; driverDone = 0;
      mPc = RST_PC; mPendValid = 0; mPendTarget = '0; mIgnore = 0;
      rst = 1; freeze = 0; stall = 0; taken = 0; jal = 0; jalr = 0;
      branch_target = '0; jalr_target = '0;
      @(posedge clk);
      applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      // move PC to 0x40, then reset from there and step sequentially
      applyStimulus(0, 0, 0, 0, 1, 0, 32'h40, 32'h0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      // taken held for three cycles; the later two fall in the squash window
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 0, 32'h80, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      // jal and jalr together: jalr wins with bit 0 cleared
      applyStimulus(0, 0, 0, 0, 1, 1, 32'h200, 32'h101);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      // redirect arriving during a three-cycle freeze
      applyStimulus(0, 1, 0, 1, 0, 0, 32'h300, 32'h0);
      for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      // redirect beats stall, then stall alone holds
      applyStimulus(0, 0, 1, 0, 1, 0, 32'h44, 32'h0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
      // PC wrap from the top of the address space
      applyStimulus(0, 0, 0, 0, 0, 1, 32'h0, 32'hFFFF_FFFF);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      // reset while a redirect is pending discards it
      applyStimulus(0, 1, 0, 0, 1, 0, 32'h500, 32'h0);
      applyStimulus(1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         applyStimulus(($urandom_range(0, 63) == 0),
                       ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 4) == 0),
                       ($urandom_range(0, 9) == 0),
                       ($urandom_range(0, 9) == 0),
                       $urandom(), $urandom());
      end
      driverDone = 1;
      drain = 0;
      while (expQ.size() > 0 && drain < 10) begin
         @(posedge clk);
         drain++;
      end
      if (expQ.size() > 0) begin
         miscompares++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
